// File: rtl/csr_file_wb_if.sv
`default_nettype none
// ============================================================================
// csr_file_wb_if : WB-stage CSR write bus and EX-stage CSR read port
// Revision 1.0
// ============================================================================
interface csr_file_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic              bubbleW;
  logic              flushW;
  logic              csrreg_write_en_WB;
  logic [1:0]        csr_op_WB;
  logic [ADDR_W-1:0] csr_addr_WB;
  logic [DATA_W-1:0] csr_wdata_WB;
  logic              retire_WB;
  logic [ADDR_W-1:0] csr_raddr_EX;
  logic [DATA_W-1:0] csr_rdata_EX;
  logic              csr_illegal_EX;

  modport master (
    output bubbleW, flushW, csrreg_write_en_WB, csr_op_WB, csr_addr_WB,
           csr_wdata_WB, retire_WB, csr_raddr_EX,
    input  csr_rdata_EX, csr_illegal_EX
  );

  modport slave (
    input  bubbleW, flushW, csrreg_write_en_WB, csr_op_WB, csr_addr_WB,
           csr_wdata_WB, retire_WB, csr_raddr_EX,
    output csr_rdata_EX, csr_illegal_EX
  );
endinterface
`default_nettype wire

// File: rtl/csr_file_wb.sv
`default_nettype none
// ============================================================================
// csr_file_wb : WB-stage CSR register file with bypassed EX read port
// Revision 1.0 ; define CSR_COUNTERS_EN to add 64-bit mcycle/minstret
// ============================================================================
module csr_file_wb #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 12,
  parameter int                NUM_CSR  = 8,
  parameter logic [ADDR_W-1:0] CSR_BASE = ADDR_W'(12'h300)
) (
  input  logic         clk,
  input  logic         rst_n,
  csr_file_wb_if.slave bus
);

  localparam logic [1:0]        C_OP_NONE = 2'b00;
  localparam logic [1:0]        C_OP_RW   = 2'b01;
  localparam logic [1:0]        C_OP_RS   = 2'b10;
  localparam logic [1:0]        C_OP_RC   = 2'b11;
  localparam int                IDX_W     = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;
  localparam logic [ADDR_W-1:0] C_NUM     = ADDR_W'(NUM_CSR);

  logic [DATA_W-1:0] slot_q [NUM_CSR];
  logic [DATA_W-1:0] slot_d [NUM_CSR];

  logic [ADDR_W-1:0] w_wr_off, w_rd_off;
  logic [IDX_W-1:0]  w_wr_idx, w_rd_idx;
  logic              w_wr_slot, w_rd_slot;
  logic              w_wr_cnt, w_rd_cnt;
  logic [DATA_W-1:0] w_wr_cnt_old, w_rd_cnt_val;
  logic              w_wr_legal, w_rd_legal, w_commit;
  logic [DATA_W-1:0] w_wr_old, w_wr_new, w_rd_stored;

  // Unsigned offset wraps for addresses below the base, so one compare covers both bounds
  assign w_wr_off  = bus.csr_addr_WB - CSR_BASE;
  assign w_rd_off  = bus.csr_raddr_EX - CSR_BASE;
  assign w_wr_slot = (w_wr_off < C_NUM);
  assign w_rd_slot = (w_rd_off < C_NUM);
  assign w_wr_idx  = w_wr_off[IDX_W-1:0];
  assign w_rd_idx  = w_rd_off[IDX_W-1:0];

`ifdef CSR_COUNTERS_EN
  localparam int                CNT_W         = 2 * DATA_W;
  localparam logic [ADDR_W-1:0] C_MCYCLE_LO   = ADDR_W'(12'hB00);
  localparam logic [ADDR_W-1:0] C_MCYCLE_HI   = ADDR_W'(12'hB80);
  localparam logic [ADDR_W-1:0] C_MINSTRET_LO = ADDR_W'(12'hB02);
  localparam logic [ADDR_W-1:0] C_MINSTRET_HI = ADDR_W'(12'hB82);

  logic [CNT_W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic             w_retire;

  function automatic logic [DATA_W:0] cnt_sel(input logic [ADDR_W-1:0] addr,
                                              input logic [CNT_W-1:0]  mc,
                                              input logic [CNT_W-1:0]  mi);
    logic [DATA_W:0] r;
    r = '0;
    case (addr)
      C_MCYCLE_LO:   r = {1'b1, mc[DATA_W-1:0]};
      C_MCYCLE_HI:   r = {1'b1, mc[CNT_W-1:DATA_W]};
      C_MINSTRET_LO: r = {1'b1, mi[DATA_W-1:0]};
      C_MINSTRET_HI: r = {1'b1, mi[CNT_W-1:DATA_W]};
      default:       r = '0;
    endcase
    return r;
  endfunction

  assign {w_wr_cnt, w_wr_cnt_old} = cnt_sel(bus.csr_addr_WB, mcycle_q, minstret_q);
  assign {w_rd_cnt, w_rd_cnt_val} = cnt_sel(bus.csr_raddr_EX, mcycle_q, minstret_q);
  assign w_retire = bus.retire_WB & ~bus.bubbleW & ~bus.flushW;

  // A committed half-write replaces the increment for that counter; no carry across halves
  always_comb begin
    mcycle_d   = mcycle_q + CNT_W'(1);
    minstret_d = minstret_q + CNT_W'(w_retire);
    if (w_commit) begin
      case (bus.csr_addr_WB)
        C_MCYCLE_LO:   mcycle_d   = {mcycle_q[CNT_W-1:DATA_W], w_wr_new};
        C_MCYCLE_HI:   mcycle_d   = {w_wr_new, mcycle_q[DATA_W-1:0]};
        C_MINSTRET_LO: minstret_d = {minstret_q[CNT_W-1:DATA_W], w_wr_new};
        C_MINSTRET_HI: minstret_d = {w_wr_new, minstret_q[DATA_W-1:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  logic w_unused;
  assign w_unused     = bus.retire_WB;
  assign w_wr_cnt     = 1'b0;
  assign w_rd_cnt     = 1'b0;
  assign w_wr_cnt_old = '0;
  assign w_rd_cnt_val = '0;
`endif

  assign w_wr_legal = w_wr_slot | w_wr_cnt;
  assign w_rd_legal = w_rd_slot | w_rd_cnt;
  assign w_commit   = bus.csrreg_write_en_WB & ~bus.bubbleW & ~bus.flushW &
                      (bus.csr_op_WB != C_OP_NONE) & w_wr_legal;
  assign w_wr_old   = w_wr_slot ? slot_q[w_wr_idx] : w_wr_cnt_old;

  always_comb begin
    w_wr_new = w_wr_old;
    case (bus.csr_op_WB)
      C_OP_RW: w_wr_new = bus.csr_wdata_WB;
      C_OP_RS: w_wr_new = w_wr_old | bus.csr_wdata_WB;
      C_OP_RC: w_wr_new = w_wr_old & ~bus.csr_wdata_WB;
      default: w_wr_new = w_wr_old;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_CSR; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (w_commit && w_wr_slot) begin
      slot_d[w_wr_idx] = w_wr_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CSR; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CSR; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign w_rd_stored = w_rd_slot ? slot_q[w_rd_idx] :
                       (w_rd_cnt ? w_rd_cnt_val : '0);

  // Same-cycle WB->EX bypass; commit already implies the address is legal
  assign bus.csr_rdata_EX   = (w_commit && (bus.csr_addr_WB == bus.csr_raddr_EX)) ?
                              w_wr_new : w_rd_stored;
  assign bus.csr_illegal_EX = ~w_rd_legal;

endmodule
`default_nettype wire

// File: tb/tb_csr_file_wb.sv
`default_nettype none
// ============================================================================
// tb_csr_file_wb : directed scoreboard bench for csr_file_wb
// Revision 1.0 ; counter checks enabled when CSR_COUNTERS_EN is defined
// ============================================================================
module tb_csr_file_wb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_file_wb_if #(.DATA_W(32), .ADDR_W(12)) bus ();

  csr_file_wb #(
    .DATA_W  (32),
    .ADDR_W  (12),
    .NUM_CSR (8),
    .CSR_BASE(12'h300)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] model [8];

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no entry, required one");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    assert (bus.csr_rdata_EX === e.data) else begin
      n_fail++;
      $error("FAIL %s rdata: got %h required %h", e.tag, bus.csr_rdata_EX, e.data);
    end
    n_cmp++;
    assert (bus.csr_illegal_EX === e.ill) else begin
      n_fail++;
      $error("FAIL %s illegal: got %b required %b", e.tag, bus.csr_illegal_EX, e.ill);
    end
  endtask

  task automatic probe(input string tag, input logic [11:0] a,
                       input logic [31:0] d, input logic il);
    exp_t e;
    e.tag = tag;
    e.data = d;
    e.ill = il;
    bus.csr_raddr_EX = a;
    sb.push_back(e);
    #1;
    check_out();
  endtask

  task automatic rd(input string tag, input logic [11:0] a,
                    input logic [31:0] d, input logic il);
    @(negedge clk);
    probe(tag, a, d, il);
  endtask

  task automatic clear_wb();
    bus.csrreg_write_en_WB = 1'b0;
    bus.csr_op_WB          = 2'b00;
    bus.bubbleW            = 1'b0;
    bus.flushW             = 1'b0;
    bus.retire_WB          = 1'b0;
  endtask

  task automatic drive_wr(input logic [1:0] op, input logic [11:0] a,
                          input logic [31:0] d, input logic bub, input logic fl);
    bus.csrreg_write_en_WB = 1'b1;
    bus.csr_op_WB          = op;
    bus.csr_addr_WB        = a;
    bus.csr_wdata_WB       = d;
    bus.bubbleW            = bub;
    bus.flushW             = fl;
  endtask

  task automatic model_upd(input logic [1:0] op, input logic [11:0] a,
                           input logic [31:0] d, input logic bub, input logic fl);
    logic [11:0] off;
    off = a - 12'h300;
    if (!bub && !fl && op != 2'b00 && a >= 12'h300 && a < 12'h308) begin
      case (op)
        2'b01:   model[off[2:0]] = d;
        2'b10:   model[off[2:0]] = model[off[2:0]] | d;
        default: model[off[2:0]] = model[off[2:0]] & ~d;
      endcase
    end
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a,
                    input logic [31:0] d, input logic bub, input logic fl);
    @(negedge clk);
    drive_wr(op, a, d, bub, fl);
    @(posedge clk);
    #1;
    clear_wb();
    model_upd(op, a, d, bub, fl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_wb();
    bus.csr_addr_WB  = '0;
    bus.csr_wdata_WB = '0;
    bus.csr_raddr_EX = '0;
    for (int i = 0; i < 8; i++) model[i] = '0;

    // T1: reset state, read while rst_n is low
    for (int i = 0; i < 8; i++) rd($sformatf("t1_slot%0d", i), 12'h300 + 12'(i), 32'h0, 1'b0);
    rd("t1_illegal_400", 12'h400, 32'h0, 1'b1);
    rd("t1_illegal_2ff", 12'h2FF, 32'h0, 1'b1);
    rd("t1_illegal_308", 12'h308, 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // T2: RW / RS / RC
    wr(2'b01, 12'h301, 32'h0000_00F0, 1'b0, 1'b0);
    rd("t2_rw", 12'h301, 32'h0000_00F0, 1'b0);
    wr(2'b10, 12'h301, 32'h0000_000F, 1'b0, 1'b0);
    rd("t2_rs", 12'h301, 32'h0000_00FF, 1'b0);
    wr(2'b11, 12'h301, 32'h0000_0030, 1'b0, 1'b0);
    rd("t2_rc", 12'h301, 32'h0000_00CF, 1'b0);

    // T3: same-cycle bypass, and no bypass when bubbled
    @(negedge clk);
    drive_wr(2'b01, 12'h302, 32'hDEAD_BEEF, 1'b0, 1'b0);
    probe("t3_bypass", 12'h302, 32'hDEAD_BEEF, 1'b0);
    @(posedge clk);
    #1;
    clear_wb();
    model_upd(2'b01, 12'h302, 32'hDEAD_BEEF, 1'b0, 1'b0);
    rd("t3_stored", 12'h302, model[2], 1'b0);
    @(negedge clk);
    drive_wr(2'b01, 12'h302, 32'h0000_0001, 1'b1, 1'b0);
    probe("t3_no_bypass_bubble", 12'h302, 32'hDEAD_BEEF, 1'b0);
    @(posedge clk);
    #1;
    clear_wb();

    // T4: suppressed writes
    wr(2'b01, 12'h303, 32'h0000_1234, 1'b1, 1'b0);
    wr(2'b01, 12'h303, 32'h0000_1234, 1'b0, 1'b1);
    wr(2'b01, 12'h303, 32'h0000_1234, 1'b1, 1'b1);
    wr(2'b01, 12'h400, 32'h0000_1234, 1'b0, 1'b0);
    wr(2'b00, 12'h304, 32'h0000_1234, 1'b0, 1'b0);
    rd("t4_303_zero", 12'h303, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) rd($sformatf("t4_slot%0d", i), 12'h300 + 12'(i), model[i], 1'b0);

`ifndef CSR_COUNTERS_EN
    rd("nocnt_b00_illegal", 12'hB00, 32'h0, 1'b1);
    rd("nocnt_b82_illegal", 12'hB82, 32'h0, 1'b1);
`else
    // T5: mcycle / minstret counting from reset release
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    @(negedge clk);
    probe("t5_mcycle_in_reset", 12'hB00, 32'h0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.retire_WB = (i == 1 || i == 3 || i == 5 || i == 7);
      bus.flushW    = (i == 5);
      @(posedge clk);
      @(negedge clk);
    end
    clear_wb();
    probe("t5_mcycle_lo", 12'hB00, 32'd10, 1'b0);
    probe("t5_minstret_lo", 12'hB02, 32'd3, 1'b0);
    probe("t5_mcycle_hi", 12'hB80, 32'd0, 1'b0);
    rd("t5_slot_reset", 12'h301, model[1], 1'b0);

    // Counter-half write: bypass and suppressed increment
    @(negedge clk);
    drive_wr(2'b01, 12'hB02, 32'd5, 1'b0, 1'b0);
    bus.retire_WB = 1'b1;
    probe("t5_minstret_bypass", 12'hB02, 32'd5, 1'b0);
    @(posedge clk);
    #1;
    clear_wb();
    rd("t5_minstret_written", 12'hB02, 32'd5, 1'b0);
    bus.retire_WB = 1'b1;
    bus.bubbleW   = 1'b1;
    @(posedge clk);
    #1;
    clear_wb();
    rd("t5_minstret_bubble", 12'hB02, 32'd5, 1'b0);
    bus.retire_WB = 1'b1;
    @(posedge clk);
    #1;
    clear_wb();
    rd("t5_minstret_retire", 12'hB02, 32'd6, 1'b0);

    // T6: mcycle wrap
    wr(2'b01, 12'hB80, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    probe("t6_mcycle_lo_max", 12'hB00, 32'hFFFF_FFFF, 1'b0);
    probe("t6_mcycle_hi_max", 12'hB80, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    probe("t6_mcycle_lo_wrap", 12'hB00, 32'h0, 1'b0);
    probe("t6_mcycle_hi_wrap", 12'hB80, 32'h0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
